// File: rtl/conv_pre_ctrl.sv
// conv_pre_ctrl: frame sequencer in front of the 3x3 DW / PW preprocess block.
// Ports: clk, rst (sync, active-high); start + cfg_width/cfg_height/cfg_pw_mode
//   request a frame; src_valid/src_ready handshake upstream beats; pp_* drive
//   the preprocess block; win_valid marks usable windows; busy/done/cfg_err
//   report status. Optional macro CONV_PRE_CTRL_PERF_CNT_EN adds
//   perf_stall_cnt (RUN cycles with no upstream beat, saturating).
module conv_pre_ctrl #(
    parameter int DIM_WIDTH    = 9,
    parameter int MAX_WIDTH    = 320,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_WIDTH-1:0] cfg_width,
    input  logic [DIM_WIDTH-1:0] cfg_height,
    input  logic                 cfg_pw_mode,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic                 pp_valid_in,
    output logic [DIM_WIDTH-1:0] pp_buff_len_ctrl,
    output logic                 pp_buff_len_rst,
    output logic                 pp_pw_mode,
    output logic                 win_valid,
    output logic                 busy,
    output logic                 done,
`ifdef CONV_PRE_CTRL_PERF_CNT_EN
    output logic [31:0]          perf_stall_cnt,
`endif
    output logic                 cfg_err
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0]       DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] TWO = DIM_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [DIM_WIDTH-1:0] r_width;
    logic [DIM_WIDTH-1:0] r_height;
    logic                 r_pw;
    logic [DIM_WIDTH-1:0] r_buff_len;
    logic [DIM_WIDTH-1:0] r_col;
    logic [DIM_WIDTH-1:0] r_row;
    logic [DCW-1:0]       r_drain;
    logic                 r_win_valid;
    logic                 r_cfg_err;

    logic [31:0] w_w32;
    logic [31:0] w_h32;
    logic        w_cfg_legal;
    logic        w_accept;
    logic        w_beat;
    logic        w_col_wrap;
    logic        w_last;

    // Legality uses 32-bit copies so MAX_WIDTH need not fit in DIM_WIDTH.
    assign w_w32 = 32'(cfg_width);
    assign w_h32 = 32'(cfg_height);

    always_comb begin
        w_cfg_legal = 1'b0;
        if (cfg_pw_mode)
            w_cfg_legal = (w_w32 >= 32'd1) && (w_w32 <= 32'(MAX_WIDTH))
                          && (w_h32 >= 32'd1);
        else
            w_cfg_legal = (w_w32 >= 32'd3) && (w_w32 <= 32'(MAX_WIDTH))
                          && (w_h32 >= 32'd3);
    end

    assign w_accept   = (r_state == S_IDLE) && start && w_cfg_legal;
    assign w_beat     = (r_state == S_RUN) && src_valid;
    assign w_col_wrap = (r_col == r_width - ONE);
    assign w_last     = w_col_wrap && (r_row == r_height - ONE);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        src_ready       = 1'b0;
        pp_buff_len_rst = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept)
                    w_next = S_CLEAR;
            end
            S_CLEAR: begin
                pp_buff_len_rst = 1'b1;
                w_next          = S_RUN;
            end
            S_RUN: begin
                src_ready = 1'b1;
                if (w_beat && w_last)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST)
                    w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width     <= '0;
            r_height    <= '0;
            r_pw        <= 1'b0;
            r_buff_len  <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_drain     <= '0;
            r_win_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err   <= (r_state == S_IDLE) && start && !w_cfg_legal;
            // Window is judged on the pre-increment position of this beat.
            r_win_valid <= w_beat &&
                           (r_pw || ((r_row >= TWO) && (r_col >= TWO)));
            if (w_accept) begin
                r_width    <= cfg_width;
                r_height   <= cfg_height;
                r_pw       <= cfg_pw_mode;
                r_buff_len <= cfg_pw_mode ? '0 : (cfg_width - TWO);
            end
            if (r_state == S_CLEAR) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_beat) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= r_row + ONE;
                end else begin
                    r_col <= r_col + ONE;
                end
            end
            if (r_state == S_DRAIN)
                r_drain <= r_drain + DCW'(1);
            else
                r_drain <= '0;
        end
    end

`ifdef CONV_PRE_CTRL_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state == S_CLEAR))
            r_stall_cnt <= '0;
        else if ((r_state == S_RUN) && !src_valid && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

    assign pp_valid_in      = w_beat;
    assign pp_buff_len_ctrl = r_buff_len;
    assign pp_pw_mode       = r_pw;
    assign win_valid        = r_win_valid;
    assign cfg_err          = r_cfg_err;

endmodule
